grid_scanout: RTL and testbench

GRID_SCANOUT -- requirements
Module: grid_scanout

---
 rtl/grid_scanout.sv | 181 ++++++++++++++++++
 tb/tb_grid_scanout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/grid_scanout.sv
// Purpose : scans a GRID_ROWS x GRID_COLS bitmap out as a raster video stream, one cell = CELL_W x CELL_H pixels.
// Latency : every video output (rgb/de/hs/vs/frame_start) lags the h/v counters by exactly 2 clocks.
// Backpr. : none; free-running pixel timing, grid_ram is sampled once per frame into a shadow copy.
//
// Ports:
//   clk          pixel clock, rising edge
//   reset_n      asynchronous active-low reset
//   grid_ram     cell bitmap, bit r*GRID_COLS+c = row r, column c
//   vid_rgb      {R,G,B}: white for a set cell, black for a clear cell or outside the active area
//   vid_de       data enable, high in the active area
//   vid_hs       horizontal sync, active high
//   vid_vs       vertical sync, active high (whole lines)
//   frame_start  one-cycle pulse with the first active pixel of each frame
//
// Optional macro GRID_LINES_EN: draws a dark-grey grid on the first pixel column and
// first line of every cell, overriding the cell colour.
module grid_scanout #(
  parameter int RAM_LENGTH = 1200,
  parameter int GRID_ROWS  = 30,
  parameter int GRID_COLS  = 40,
  parameter int CELL_W     = 8,
  parameter int CELL_H     = 8,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 32,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [0:RAM_LENGTH-1] grid_ram,
  output logic [23:0]           vid_rgb,
  output logic                  vid_de,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  frame_start
);

  localparam int H_ACT = GRID_COLS * CELL_W;
  localparam int V_ACT = GRID_ROWS * CELL_H;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int IW    = $clog2(RAM_LENGTH);
  localparam int CW_SH = $clog2(CELL_W);
  localparam int CH_SH = $clog2(CELL_H);

  // Timing counters
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap, v_wrap;

  // Frame snapshot of grid_ram
  logic [0:RAM_LENGTH-1] shadow_q, shadow_d;

  // Stage 0 (combinational from counters)
  logic          de0, hs0, vs0, fs0;
  logic [VW-1:0] cell_row;
  logic [HW-1:0] cell_col;
  logic [IW-1:0] cell_idx;

  // Stage 1
  logic cell1_q, cell1_d;
  logic de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
`ifdef GRID_LINES_EN
  logic gl0;
  logic gl1_q, gl1_d;
`endif

  // Stage 2 (outputs)
  logic [23:0] rgb_q, rgb_d;
  logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;

  always_comb begin
    h_wrap  = (h_cnt_q == HW'(H_TOT - 1));
    v_wrap  = (v_cnt_q == VW'(V_TOT - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
    // Snapshot taken on the very last cycle of the frame so pixel (0,0) already sees it.
    shadow_d = (h_wrap && v_wrap) ? grid_ram : shadow_q;
  end

  always_comb begin
    de0 = (h_cnt_q < HW'(H_ACT)) && (v_cnt_q < VW'(V_ACT));
    hs0 = (h_cnt_q >= HW'(H_ACT + H_FP)) && (h_cnt_q < HW'(H_ACT + H_FP + H_SYNC));
    vs0 = (v_cnt_q >= VW'(V_ACT + V_FP)) && (v_cnt_q < VW'(V_ACT + V_FP + V_SYNC));
    fs0 = (h_cnt_q == '0) && (v_cnt_q == '0);
    cell_row = v_cnt_q >> CH_SH;
    cell_col = h_cnt_q >> CW_SH;
    // Index forced to 0 in blanking so it can never point past the bitmap.
    cell_idx = '0;
    if (de0) begin
      cell_idx = IW'(cell_row) * IW'(GRID_COLS) + IW'(cell_col);
    end
`ifdef GRID_LINES_EN
    gl0 = de0 && (((h_cnt_q & HW'(CELL_W - 1)) == '0) || ((v_cnt_q & VW'(CELL_H - 1)) == '0));
`endif
  end

  always_comb begin
    cell1_d = de0 ? shadow_q[cell_idx] : 1'b0;
    de1_d   = de0;
    hs1_d   = hs0;
    vs1_d   = vs0;
    fs1_d   = fs0;
`ifdef GRID_LINES_EN
    gl1_d   = gl0;
`endif
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (de1_q) begin
`ifdef GRID_LINES_EN
      if (gl1_q) begin
        rgb_d = 24'h404040;
      end else if (cell1_q) begin
        rgb_d = 24'hFFFFFF;
      end
`else
      if (cell1_q) begin
        rgb_d = 24'hFFFFFF;
      end
`endif
    end
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    fs2_d = fs1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      shadow_q <= '0;
      cell1_q  <= 1'b0;
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      fs1_q    <= 1'b0;
`ifdef GRID_LINES_EN
      gl1_q    <= 1'b0;
`endif
      rgb_q    <= '0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      fs2_q    <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      shadow_q <= shadow_d;
      cell1_q  <= cell1_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      fs1_q    <= fs1_d;
`ifdef GRID_LINES_EN
      gl1_q    <= gl1_d;
`endif
      rgb_q    <= rgb_d;
      de2_q    <= de2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      fs2_q    <= fs2_d;
    end
  end

  assign vid_rgb     = rgb_q;
  assign vid_de      = de2_q;
  assign vid_hs      = hs2_q;
  assign vid_vs      = vs2_q;
  assign frame_start = fs2_q;

endmodule

// File: tb/tb_grid_scanout.sv
// Purpose : self-checking bench for grid_scanout on a reduced raster (5x4 cells of 4x4 pixels).
// Latency : expected pixels are queued per counter step and popped when the DUT's 2-cycle pipeline delivers them.
// Backpr. : none.
module tb_grid_scanout;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int RAM   = ROWS * COLS;
  localparam int CW    = 4;
  localparam int CH    = 4;
  localparam int HFP   = 3;
  localparam int HSY   = 4;
  localparam int HBP   = 5;
  localparam int VFP   = 2;
  localparam int VSY   = 3;
  localparam int VBP   = 2;
  localparam int HACT  = COLS * CW;                 // 20
  localparam int VACT  = ROWS * CH;                 // 16
  localparam int HTOT  = HACT + HFP + HSY + HBP;    // 32
  localparam int VTOT  = VACT + VFP + VSY + VBP;    // 23
  localparam int FRAME = HTOT * VTOT;               // 736

  logic           clk = 1'b0;
  logic           reset_n;
  logic [0:RAM-1] grid_ram;
  logic [23:0]    vid_rgb;
  logic           vid_de, vid_hs, vid_vs, frame_start;

  always #5 clk = ~clk;

  grid_scanout #(
    .RAM_LENGTH(RAM), .GRID_ROWS(ROWS), .GRID_COLS(COLS),
    .CELL_W(CW), .CELL_H(CH),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .grid_ram(grid_ram),
    .vid_rgb(vid_rgb),
    .vid_de(vid_de),
    .vid_hs(vid_hs),
    .vid_vs(vid_vs),
    .frame_start(frame_start)
  );

  int             n_cmp = 0;
  int             n_err = 0;
  int             mh, mv;
  logic [0:RAM-1] m_shadow;
  logic [27:0]    sb_q[$];
  int             cyc = 0;
  int             last_fs;
  bit             fs_seen;
  int             white_cnt;

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference pixel for counter position (h,v): {rgb, de, hs, vs, frame_start}
  function automatic logic [27:0] model_px(input int h, input int v);
    logic        de, hs, vs, fs, bit_set, gl;
    logic [23:0] rgb;
    de = (h < HACT) && (v < VACT);
    hs = (h >= HACT + HFP) && (h < HACT + HFP + HSY);
    vs = (v >= VACT + VFP) && (v < VACT + VFP + VSY);
    fs = (h == 0) && (v == 0);
    bit_set = de ? m_shadow[(v / CH) * COLS + (h / CW)] : 1'b0;
`ifdef GRID_LINES_EN
    gl = de && ((h % CW == 0) || (v % CH == 0));
`else
    gl = 1'b0;
`endif
    rgb = !de ? 24'h000000 : gl ? 24'h404040 : bit_set ? 24'hFFFFFF : 24'h000000;
    return {rgb, de, hs, vs, fs};
  endfunction

  function automatic logic [27:0] dut_px();
    return {vid_rgb, vid_de, vid_hs, vid_vs, frame_start};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    m_shadow = '0;
    sb_q.delete();
    sb_q.push_back('0);   // stage-2 reset contents seen on the first edge after release
    fs_seen = 1'b0;
  endtask

  task automatic step();
    sb_q.push_back(model_px(mh, mv));
    @(posedge clk);
    if (mh == HTOT - 1 && mv == VTOT - 1) m_shadow = grid_ram;
    if (mh == HTOT - 1) begin
      mh = 0;
      mv = (mv == VTOT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    #1;
    cyc++;
    check("pix", dut_px(), sb_q.pop_front());
    if (vid_rgb == 24'hFFFFFF) white_cnt++;
    if (frame_start) begin
      if (fs_seen) check("fs_period", 28'(cyc - last_fs), 28'(FRAME));
      fs_seen = 1'b1;
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    int exp_white;
    reset_n  = 1'b0;
    grid_ram = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", dut_px(), '0);
    reset_n = 1'b1;

    // Frame 1: black shadow; corner cells requested mid-frame, shown from frame 2.
    run(FRAME / 2);
    grid_ram[0]       = 1'b1;
    grid_ram[RAM - 1] = 1'b1;
    run(FRAME - FRAME / 2);

    // Frame 2: cell (1,1) toggled mid-frame must not appear until frame 3.
    white_cnt = 0;
    run(FRAME / 3);
    grid_ram[COLS + 1] = ~grid_ram[COLS + 1];
    run(FRAME - FRAME / 3);
`ifdef GRID_LINES_EN
    exp_white = 2 * (CW - 1) * (CH - 1);
`else
    exp_white = 2 * CW * CH;
`endif
    check("white_frame2", 28'(white_cnt), 28'(exp_white));

    // Frame 3 onward: grid_ram churns throughout.
    for (int k = 0; k < 9; k++) begin
      grid_ram = RAM'($urandom);
      run(97);
    end

    // Reset in the middle of an active line.
    guard = 0;
    while (!(mv < VACT && mv > 0 && mh == HACT / 2) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("find_midline", 28'(guard < 2 * FRAME), 28'(1));
    reset_n = 1'b0;
    #1;
    check("rst_async", dut_px(), '0);
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("rst_hold", dut_px(), '0);
    reset_n  = 1'b1;
    grid_ram = RAM'(32'h000A_5A5A);

    // First frame after reset is black; snapshot shows from the frame after.
    run(2 * FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(20 * FRAME * 10 * 2);
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
